// File: rtl/imm_encoder_if.sv
// Request/response stream bundle for the immediate encoder.
// The producer side (master) issues requests and accepts encoded words; the encoder is the slave.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, imm_type, imm, base_instr, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, imm_type, imm, base_instr, out_ready,
    output in_ready, out_valid, instr, err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/U/J bit positions of a base instruction word.
// Two-stage valid/ready pipeline: stage 1 captures the request and range flag, stage 2 the merged word.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic        load1;
  logic        load2;

  // True when the immediate cannot round-trip through the selected format.
  function automatic logic range_err(input logic [2:0] t, input logic [31:0] v);
    logic e;
    case (t)
      IMM_I, IMM_S: e = !((&v[31:11]) || !(|v[31:11]));
      IMM_B:        e = !((&v[31:12]) || !(|v[31:12])) || v[0];
      IMM_J:        e = !((&v[31:20]) || !(|v[31:20])) || v[0];
      IMM_U:        e = |v[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] t, input logic [31:0] v,
                                        input logic [31:0] b);
    logic [31:0] w;
    case (t)
      IMM_I:   w = {v[11:0], b[19:0]};
      IMM_S:   w = {v[11:5], b[24:12], v[4:0], b[6:0]};
      IMM_B:   w = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
      IMM_U:   w = {v[31:12], b[11:0]};
      IMM_J:   w = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
      default: w = b;
    endcase
    return w;
  endfunction

  assign load2 = !s2_valid || bus.out_ready;
  assign load1 = !s1_valid || load2;

  assign bus.in_ready  = load1;
  assign bus.out_valid = s2_valid;
  assign bus.instr     = s2_instr;
  assign bus.err       = s2_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_type  <= 3'd0;
      s1_imm   <= 32'd0;
      s1_base  <= 32'd0;
      s1_err   <= 1'b0;
    end else if (load1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_type  <= bus.imm_type;
        s1_imm   <= bus.imm;
        s1_base  <= bus.base_instr;
        s1_err   <= range_err(bus.imm_type, bus.imm);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'd0;
      s2_err   <= 1'b0;
    end else if (load2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= merge(s1_type, s1_imm, s1_base);
        s2_err   <= s1_err;
      end
    end
  end

  // Counts only errored words actually taken downstream; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && bus.out_ready && s2_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: formats, range errors, backpressure, streaming, saturation, async reset.
// Uses CNT_W=2 so counter saturation is reachable with a handful of words.
module tb_imm_encoder;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] err_count;
  int         checks = 0;
  int         errors = 0;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Drives one request into an empty pipeline and returns the first word seen plus its latency.
  task automatic send_one(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b,
                          output logic [31:0] o_instr, output logic o_err, output int lat);
    @(negedge clk);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.imm_type   = t;
    bus.imm        = v;
    bus.base_instr = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    o_instr = bus.instr;
    o_err   = bus.err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.imm_type   = IMM_I;
    bus.imm        = 32'd0;
    bus.base_instr = 32'd0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", bus.instr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_formats;
    logic [2:0]  t   [5] = '{IMM_I, IMM_S, IMM_B, IMM_J, IMM_U};
    logic [31:0] v   [5] = '{32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000};
    logic [31:0] b   [5] = '{32'h0000_0093, 32'h0020_A023, 32'h0000_0063, 32'h0000_00EF, 32'h0000_00B7};
    logic [31:0] exp [5] = '{32'hFFF0_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h0010_00EF, 32'h1234_50B7};
    logic [31:0] o;
    logic        e;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      send_one(t[i], v[i], b[i], o, e, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL fmt%0d_latency: got %0d want 2", i, lat); end
      checks++; if (o !== exp[i]) begin errors++; $display("FAIL fmt%0d_instr: got %h want %h", i, o, exp[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL fmt%0d_err: got %b want 0", i, e); end
    end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL fmt_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_errors;
    logic [2:0]  t   [3] = '{IMM_I, IMM_B, 3'd7};
    logic [31:0] v   [3] = '{32'h0000_0800, 32'h0000_0007, 32'h0000_0123};
    logic [31:0] b   [3] = '{32'h0000_0093, 32'h0000_0063, 32'h0000_0013};
    logic [31:0] exp [3] = '{32'h8000_0093, 32'h0000_0363, 32'h0000_0013};
    logic [31:0] o;
    logic        e;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      send_one(t[i], v[i], b[i], o, e, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL err%0d_latency: got %0d want 2", i, lat); end
      checks++; if (o !== exp[i]) begin errors++; $display("FAIL err%0d_instr: got %h want %h", i, o, exp[i]); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err%0d_err: got %b want 1", i, e); end
      checks++; if (err_count !== 2'(i + 1)) begin errors++; $display("FAIL err%0d_count: got %0d want %0d", i, err_count, i + 1); end
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.imm_type = IMM_I; bus.imm = 32'd1; bus.base_instr = 32'h13;
    if (bus.in_ready) acc++;
    @(negedge clk);
    bus.imm = 32'd2;
    if (bus.in_ready) acc++;
    @(negedge clk);
    bus.imm = 32'd3;
    if (bus.in_ready) acc++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low%0d: got %b want 0", k, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.instr !== 32'h0010_0013) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 00100013", k, bus.out_valid, bus.instr); end
      @(negedge clk);
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_comb: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.instr !== 32'h0020_0013) begin
      errors++; $display("FAIL bp_out1: got v=%b %h want v=1 00200013", bus.out_valid, bus.instr); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.instr !== 32'h0030_0013) begin
      errors++; $display("FAIL bp_out2: got v=%b %h want v=1 00300013", bus.out_valid, bus.instr); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4] = '{32'h0000_1037, 32'h0000_2037, 32'h0000_3037, 32'h0000_4037};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.in_valid = 1'b1; bus.imm_type = IMM_U; bus.imm = 32'(i + 1) << 12; bus.base_instr = 32'h37;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready: got %b want 1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (i >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.instr !== exp[i-2]) begin
          errors++; $display("FAIL b2b%0d_out: got v=%b %h want v=1 %h", i - 2, bus.out_valid, bus.instr, exp[i-2]); end
      end
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation;
    logic [31:0] o;
    logic        e;
    int          lat;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_one(3'd6, 32'h0, 32'h13, o, e, lat);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL sat%0d_err: got %b want 1", k, e); end
      checks++; if (err_count !== ((k >= 2) ? 2'd3 : 2'(k + 1))) begin
        errors++; $display("FAIL sat%0d_count: got %0d want %0d", k, err_count, (k >= 2) ? 3 : k + 1); end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.imm_type = 3'd7; bus.imm = 32'h0; bus.base_instr = 32'h13;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL arst_err_count: got %0d want 0", err_count); end
    checks++; if (bus.instr !== 32'd0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL arst_data: got %h/%b want 00000000/0", bus.instr, bus.err); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_flushed%0d: got %b want 0", k, bus.out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_formats();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
